// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end sequencer.
package calc_pkg;

  // Largest operand that decimal digit entry may build (8 digits).
  localparam int unsigned MAX_ENTRY = 99_999_999;

  // Display pattern shown after an ALU error; callers truncate it to their width.
  localparam logic [63:0] ERR_DISPLAY = '1;

  // Operator key codes as presented on the opcode input (3'b111 is reserved).
  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_EQ   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_DIV  = 3'b101,
    OP_CLR  = 3'b110
  } opcode_e;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_EXEC,
    ST_SHOW,
    ST_ERR
  } state_e;

  // True for the four codes that name an ALU operation.
  function automatic logic is_arith(input logic [2:0] code);
    return (code >= OP_ADD) && (code <= OP_DIV);
  endfunction

endpackage

// File: rtl/calc_controller_key_event.sv
// Press detector for the one-hot digit buttons: one registered event per
// press, with the pressed button encoded as a 4-bit digit.
module calc_controller_key_event (
  input  logic       clk,
  input  logic       pwr,
  input  logic [9:0] btn,
  output logic       evt,
  output logic [3:0] digit
);

  logic [9:0] btn_prev;
  logic [3:0] code;

  // Encode the highest set button; only consulted when btn is one-hot.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    code = '0;
    for (int i = 0; i < 10; i++) begin
      if (btn[i]) code = 4'(i);
    end
  end

  // Edge detect: a press counts only if the previous sample was all-zero and
  // this one is a single button, so a multi-button press is dropped entirely.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (pwr) begin
      btn_prev <= '0;
      evt      <= 1'b0;
      digit    <= '0;
    end else begin
      btn_prev <= btn;
      evt      <= (btn_prev == '0) && $onehot(btn);
      digit    <= code;
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Calculator front-end: decimal operand entry, operator latch and a single
// outstanding req/done transaction to the shared ALU.
module calc_controller #(
  parameter int          WIDTH     = 32,
  parameter int unsigned MAX_ENTRY = calc_pkg::MAX_ENTRY
) (
  input  logic             clk,
  input  logic             pwr,
  input  logic [9:0]       btn,
  input  logic [2:0]       opcode,
  output logic             alu_req,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] displayedNum,
  output logic             err,
  output logic             busy
);

  import calc_pkg::*;

  localparam int EW = WIDTH + 4;

  // Event registers
  logic       digit_evt;
  logic [3:0] digit;
  logic [2:0] opcode_prev;
  logic       key_evt;
  logic [2:0] key_code;

  // Sequencer state and its next values
  state_e           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] a_reg, a_n;
  opcode_e          op_reg, op_n;
  opcode_e          pend_op, pend_n;
  logic             b_typed, b_typed_n;
  logic [WIDTH-1:0] disp_n;
  logic             err_n, req_n, busy_n;
  logic [WIDTH-1:0] alu_a_n, alu_b_n;
  logic [2:0]       alu_op_n;

  // Decoded events for this cycle; a key event suppresses a coincident digit.
  logic is_clr, is_eq, is_op, is_dig;
  logic [EW-1:0]    acc_wide, entry_wide;
  logic             entry_ok;
  logic [WIDTH-1:0] entry_val;

  calc_controller_key_event u_key_event (
    .clk   (clk),
    .pwr   (pwr),
    .btn   (btn),
    .evt   (digit_evt),
    .digit (digit)
  );

  // Opcode press detector: event on the first non-zero code after zero.
  always_ff @(posedge clk) begin
    if (pwr) begin
      opcode_prev <= '0;
      key_evt     <= 1'b0;
      key_code    <= '0;
    end else begin
      opcode_prev <= opcode;
      key_evt     <= (opcode_prev == 3'b000) && (opcode != 3'b000);
      key_code    <= opcode;
    end
  end

  // Event decode and the candidate value for a digit appended to acc.
  always_comb begin
    is_clr     = key_evt && (key_code == OP_CLR);
    is_eq      = key_evt && (key_code == OP_EQ);
    is_op      = key_evt && is_arith(key_code);
    is_dig     = digit_evt && !key_evt;
    acc_wide   = {4'b0000, acc};
    entry_wide = (acc_wide << 3) + (acc_wide << 1) + EW'(digit);
    entry_ok   = entry_wide <= EW'(MAX_ENTRY);
    entry_val  = entry_wide[WIDTH-1:0];
  end

  // Next-state and next-register logic; everything holds unless a case changes it.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    a_n       = a_reg;
    op_n      = op_reg;
    pend_n    = pend_op;
    b_typed_n = b_typed;
    disp_n    = displayedNum;
    err_n     = err;
    req_n     = alu_req;
    busy_n    = busy;
    alu_a_n   = alu_a;
    alu_b_n   = alu_b;
    alu_op_n  = alu_op;

    if (is_clr) begin
      // Clear outranks everything, including an alu_done arriving this cycle.
      state_n   = ST_ENTER_A;
      acc_n     = '0;
      a_n       = '0;
      op_n      = OP_NONE;
      pend_n    = OP_NONE;
      b_typed_n = 1'b0;
      disp_n    = '0;
      err_n     = 1'b0;
      req_n     = 1'b0;
      busy_n    = 1'b0;
      alu_a_n   = '0;
      alu_b_n   = '0;
      alu_op_n  = '0;
    end else begin
      case (state)
        ST_ENTER_A: begin
          if (is_op) begin
            a_n       = acc;
            op_n      = opcode_e'(key_code);
            acc_n     = '0;
            b_typed_n = 1'b0;
            state_n   = ST_ENTER_B;
          end else if (is_dig && entry_ok) begin
            acc_n  = entry_val;
            disp_n = entry_val;
          end
        end

        ST_ENTER_B: begin
          if ((is_op || is_eq) && b_typed) begin
            alu_a_n   = a_reg;
            alu_b_n   = acc;
            alu_op_n  = op_reg;
            req_n     = 1'b1;
            busy_n    = 1'b1;
            b_typed_n = 1'b0;
            pend_n    = is_op ? opcode_e'(key_code) : OP_NONE;
            state_n   = ST_EXEC;
          end else if (is_op) begin
            op_n = opcode_e'(key_code);
          end else if (is_dig) begin
            b_typed_n = 1'b1;
            if (entry_ok) begin
              acc_n  = entry_val;
              disp_n = entry_val;
            end
          end
        end

        ST_EXEC: begin
          if (alu_done) begin
            req_n  = 1'b0;
            busy_n = 1'b0;
            if (alu_err) begin
              disp_n  = WIDTH'(ERR_DISPLAY);
              err_n   = 1'b1;
              state_n = ST_ERR;
            end else begin
              disp_n = alu_result;
              if (pend_op == OP_NONE) begin
                state_n = ST_SHOW;
              end else begin
                // Chained operator: the result becomes the next left operand.
                a_n       = alu_result;
                op_n      = pend_op;
                acc_n     = '0;
                b_typed_n = 1'b0;
                state_n   = ST_ENTER_B;
              end
            end
          end
        end

        ST_SHOW: begin
          if (is_op) begin
            a_n       = displayedNum;
            op_n      = opcode_e'(key_code);
            acc_n     = '0;
            b_typed_n = 1'b0;
            state_n   = ST_ENTER_B;
          end else if (is_dig) begin
            acc_n   = WIDTH'(digit);
            disp_n  = WIDTH'(digit);
            state_n = ST_ENTER_A;
          end
        end

        ST_ERR: begin
          if (is_dig) begin
            err_n   = 1'b0;
            acc_n   = WIDTH'(digit);
            disp_n  = WIDTH'(digit);
            state_n = ST_ENTER_A;
          end
        end

        default: state_n = ST_ENTER_A;
      endcase
    end
  end

  // State and datapath registers, synchronous reset on pwr.
  always_ff @(posedge clk) begin
    if (pwr) begin
      state        <= ST_ENTER_A;
      acc          <= '0;
      a_reg        <= '0;
      op_reg       <= OP_NONE;
      pend_op      <= OP_NONE;
      b_typed      <= 1'b0;
      displayedNum <= '0;
      err          <= 1'b0;
      alu_req      <= 1'b0;
      busy         <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      a_reg        <= a_n;
      op_reg       <= op_n;
      pend_op      <= pend_n;
      b_typed      <= b_typed_n;
      displayedNum <= disp_n;
      err          <= err_n;
      alu_req      <= req_n;
      busy         <= busy_n;
      alu_a        <= alu_a_n;
      alu_b        <= alu_b_n;
      alu_op       <= alu_op_n;
    end
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Front-end sequencer for the calculator's arithmetic datapath.
- Turns raw one-hot digit buttons and operator codes into decimal operand entry and an operator latch.
- Issues one request at a time to the shared ALU over a req/done handshake, then drives displayedNum.
- Sits between the button/opcode inputs and the ALU, replacing ad-hoc sequencing inside calculator.

Parameters:
- WIDTH, 32, operand/result/display width in bits
- MAX_ENTRY, 99_999_999, largest value digit entry may reach (8 decimal digits)

Ports:
- clk  in  1  system clock, rising edge
- pwr  in  1  synchronous active-high reset
- btn  in  10  digit buttons, btn[i] = digit i, one-hot when pressed
- opcode  in  3  operator key: 000 none, 001 equals, 010 add, 011 sub, 100 mul, 101 div, 110 clear, 111 reserved (ignored)
- alu_req  out  1  request to ALU, held until alu_done
- alu_op  out  3  operation code (010..101), stable while alu_req
- alu_a  out  WIDTH  left operand, stable while alu_req
- alu_b  out  WIDTH  right operand, stable while alu_req
- alu_done  in  1  one-cycle completion pulse, valid only while alu_req
- alu_result  in  WIDTH  result, valid with alu_done
- alu_err  in  1  div-by-zero/overflow, valid with alu_done
- displayedNum  out  WIDTH  value shown
- err  out  1  error indicator
- busy  out  1  high in EXEC

Behaviour:
- Reset (pwr=1 at clk edge): state ENTER_A; acc, a_reg, op_reg, pend_op, displayedNum = 0; alu_req, err, busy = 0; btn/opcode history registers cleared. Reset mid-EXEC drops alu_req on the next edge. A later alu_done is ignored.
- Event detection:
  - Digit event: registered btn_prev == 0 and btn is nonzero and one-hot. Multi-bit btn is ignored, including the whole press until btn returns to 0.
  - Key event: opcode_prev == 000 and opcode != 000.
  - One event per press. Event acted on in the cycle after the edge that samples it. Digit and key events in the same cycle: key wins, digit discarded.
- Digit entry: acc <= acc*10 + d if acc*10 + d <= MAX_ENTRY, else digit ignored. displayedNum <= new acc.
- States ENTER_A, ENTER_B, EXEC, SHOW, ERR. Flag b_typed marks a digit entered in ENTER_B.
- ENTER_A:
  - Digit: entry into acc.
  - Operator: a_reg <= acc, op_reg <= op, acc <= 0, go ENTER_B. Display unchanged.
  - Equals: no-op.
- ENTER_B:
  - Digit: entry, set b_typed.
  - Operator without b_typed: replace op_reg.
  - Operator with b_typed: launch EXEC with op_reg, pend_op <= new op.
  - Equals with b_typed: launch EXEC, pend_op <= none.
  - Equals without b_typed: no-op.
- Launch: alu_a <= a_reg, alu_b <= acc, alu_op <= op_reg, alu_req <= 1, busy <= 1. Latency from event register to alu_req high is 1 cycle.
- EXEC:
  - All digit/operator/equals events discarded.
  - On alu_done with alu_err=0: alu_req <= 0 the same edge, displayedNum <= alu_result.
    - pend_op none: go SHOW.
    - Otherwise: a_reg <= result, op_reg <= pend_op, acc <= 0, b_typed <= 0, go ENTER_B.
  - On alu_done with alu_err=1: go ERR, displayedNum <= all ones, err <= 1.
- SHOW:
  - Digit: acc <= d, go ENTER_A.
  - Operator: a_reg <= displayedNum, op_reg <= op, acc <= 0, go ENTER_B.
  - Equals: no-op.
- ERR: only clear or a digit exits. A digit clears err and behaves as a fresh ENTER_A entry.
- Clear (110), any state: all registers to reset values next edge, alu_req dropped. An alu_done coinciding with clear is discarded.
- Arithmetic: unsigned WIDTH; *10 computed as (acc<<3)+(acc<<1) in WIDTH+4 bits before the compare.

Decomposition:
- Package calc_pkg holds:
  - opcode enum (OP_NONE, OP_EQ, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CLR)
  - state enum
  - MAX_ENTRY
  - ERR_DISPLAY constant (all ones)
- One sub-module, key_event: edge detect plus one-hot check plus encode to 4-bit digit. Instantiated once for btn; opcode edge handled inline.

Test Plan:
- Reset: pwr high 2 cycles -> displayedNum=0, alu_req=0, err=0, busy=0.
- Press 5, add, 3, equals, ALU answers done/result=8 three cycles later -> alu_req with a=5, b=3, op=010, held until done; displayedNum=8; busy low afterward.
- Chain: 1,2 add 3 sub (ALU returns 15), 4 equals (ALU returns 11) -> second request a=15, b=4, op=011; displayedNum 15 then 11.
- Entry saturation: press 9 ten times -> displayedNum=99_999_999; held button 7 for 20 cycles -> exactly one digit.
- Div by zero: 8 div 0 equals, ALU done with alu_err=1 -> displayedNum=32'hFFFF_FFFF, err=1; then press 2 -> err=0, displayedNum=2.
- Clear during EXEC with alu_done same cycle -> next cycle alu_req=0, displayedNum=0, state ENTER_A, result discarded; btn=0000100100 (two-hot) -> ignored.
